// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master controller: op-codes, frame and data
// widths, FSM state encoding and the per-state counter reload values.
package spi_master_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      SHIFT = 3'd2,
      TURN  = 3'd3,
      CAPT  = 3'd4,
      GAP   = 3'd5
   } state_t;

   // Value loaded into the shared down-counter when a state is entered.
   // A state is left when the counter reads zero, so the load is (length - 1).
   function automatic logic [3:0] cnt_load(input state_t st,
                                           input int     rd_wait,
                                           input int     gap_cycles);
      logic [3:0] val;
      val = 4'd0;
      case (st)
         START:   val = 4'd0;
         SHIFT:   val = 4'(FRAME_W - 1);
         TURN:    val = 4'(rd_wait - 1);
         CAPT:    val = 4'(DATA_W - 1);
         GAP:     val = 4'(gap_cycles - 1);
         default: val = 4'd0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath of the SPI master: 10-bit parallel-in/serial-out frame register
// (MSB first) and 8-bit serial-in/parallel-out capture register (MSB first).
// All enables come from the controller FSM.
module spi_master_shifter
   import spi_master_pkg::*;
(
   input  logic               clk,
   input  logic               load_en,
   input  logic [FRAME_W-1:0] frame,
   input  logic               shift_en,
   input  logic               cap_en,
   input  logic               miso,
   output logic               mosi_bit,
   output logic [DATA_W-1:0]  cap_next
);

   logic [FRAME_W-1:0] sr_q;
   logic [DATA_W-1:0]  cap_q;

   // Frame register: load on accept, shift left once per transmitted bit.
   // NOTE: pure datapath registers carry no reset; every use is preceded by a
   // full load or eight fresh capture shifts, so their reset value never matters.
   always_ff @(posedge clk) begin
      if (load_en) begin
         sr_q <= frame;
      end else if (shift_en) begin
         sr_q <= {sr_q[FRAME_W-2:0], 1'b0};
      end
   end

   // Capture register: shift MISO in at the edge ending each capture cycle.
   always_ff @(posedge clk) begin
      if (cap_en) begin
         cap_q <= cap_next;
      end
   end

   assign mosi_bit = sr_q[FRAME_W-1];
   // Byte as it will look after the current edge; lets the controller publish
   // the reply on the very edge that samples its last bit.
   assign cap_next = {cap_q[DATA_W-2:0], miso};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller for the SPI slave/RAM wrapper (shared clk, no SCLK).
// Accepts one RAM command per valid/ready handshake, sends the 10-bit frame
// {op, data} MSB first and, for read-data, captures the 8-bit reply.
// Optional feature macro: SPI_MASTER_RD_ORDER_CHK_EN -- rejects a read-data
// command that is not preceded by a completed read-addr frame (err pulse).
module spi_master_ctrl
   import spi_master_pkg::*;
#(
   parameter int RD_WAIT    = 1,
   parameter int GAP_CYCLES = 3
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              err,
   output logic              MOSI,
   input  logic              MISO,
   output logic              SS_n
);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [1:0]        op_q;
   logic              accept;
   logic              rd_err;

   logic              ss_n_d, mosi_d, rsp_valid_d, err_d;
   logic              load_en, shift_en, cap_en;
   logic              mosi_bit;
   logic [DATA_W-1:0] cap_next;

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign accept    = cmd_valid && cmd_ready;

`ifdef SPI_MASTER_RD_ORDER_CHK_EN
   logic rd_addr_seen_q;

   // Read-order tracking: armed by a finished read-addr frame, consumed by a
   // finished read-data frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_seen_q <= 1'b0;
      end else if (state_q == SHIFT && state_d == GAP && op_q == OP_RD_ADDR) begin
         rd_addr_seen_q <= 1'b1;
      end else if (state_q == CAPT && state_d == GAP) begin
         rd_addr_seen_q <= 1'b0;
      end
   end

   assign rd_err = accept && (cmd_op == OP_RD_DATA) && !rd_addr_seen_q;
`else
   assign rd_err = 1'b0;
`endif

   // State register, shared down-counter and latched op-code.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         op_q    <= OP_WR_ADDR;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            op_q <= cmd_op;
         end
      end
   end

   // Next-state and counter logic; each state ends when the counter hits zero.
   // NOTE: every always_comb output gets a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)       state_d = rd_err ? GAP : START;
         START:                     state_d = SHIFT;
         SHIFT:   if (cnt_q == 4'd0) state_d = (op_q == OP_RD_DATA) ? TURN : GAP;
         TURN:    if (cnt_q == 4'd0) state_d = CAPT;
         CAPT:    if (cnt_q == 4'd0) state_d = GAP;
         GAP:     if (cnt_q == 4'd0) state_d = IDLE;
         default:                   state_d = IDLE;
      endcase

      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = cnt_load(state_d, RD_WAIT, GAP_CYCLES);
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   // Output decode: pin values are derived from the state being entered so the
   // registered pins line up with the state they belong to.
   always_comb begin
      ss_n_d      = !(state_d inside {START, SHIFT, TURN, CAPT});
      mosi_d      = (state_d == SHIFT) ? mosi_bit : 1'b0;
      load_en     = accept;
      shift_en    = (state_d == SHIFT);
      cap_en      = (state_q == CAPT);
      rsp_valid_d = (state_q == CAPT) && (state_d == GAP);
      err_d       = rd_err;
   end

   // Registered outputs; reset forces an idle bus and drops any partial reply.
   always_ff @(posedge clk) begin
      if (rst) begin
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         err       <= 1'b0;
      end else begin
         SS_n      <= ss_n_d;
         MOSI      <= mosi_d;
         rsp_valid <= rsp_valid_d;
         err       <= err_d;
         if (rsp_valid_d) begin
            rsp_data <= cap_next;
         end
      end
   end

   spi_master_shifter u_shifter (
      .clk      (clk),
      .load_en  (load_en),
      .frame    ({cmd_op, cmd_data}),
      .shift_en (shift_en),
      .cap_en   (cap_en),
      .miso     (MISO),
      .mosi_bit (mosi_bit),
      .cap_next (cap_next)
   );

endmodule
